hilo_muldiv: RTL and testbench
==============================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have port clk, input, 1, the only clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port hi_we, input, 1: MTHI write enable.
REQ-004 SHALL have port lo_we, input, 1: MTLO write enable.
REQ-005 SHALL have port wdata, input, 32: MTHI/MTLO write data.
REQ-006 SHALL have port op_start, input, 1: request a multiply/divide operation.
REQ-007 SHALL have port op_sel, input, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-008 SHALL have port src_a, input, 32: multiplicand or dividend (rs).
REQ-009 SHALL have port src_b, input, 32: multiplier or divisor (rt).
REQ-010 SHALL have port flush, input, 1: abort any in-flight division.
REQ-011 SHALL have port busy, output, 1: pipeline stall request.
REQ-012 SHALL have port done, output, 1: division completion pulse.
REQ-013 SHALL have ports hi_o and lo_o, output, 32 each: registered HI/LO contents, with no bypass; these feed MFHI/MFLO.

Function
REQ-014 In IDLE with op_start and MULT/MULTU, SHALL write HI/LO at the next edge with the signed/unsigned 64-bit product: HI gets the upper word, LO the lower word.
REQ-015 In IDLE with op_start and DIV/DIVU, SHALL latch operands and enter DIV.
- Busy is combinational: it SHALL be 1 in the accept cycle and throughout DIV and FIN.
REQ-016 DIV SHALL run exactly 32 cycles, one restoring iteration per cycle.
- Iterations use absolute values and a 33-bit partial remainder.
- A 5-bit counter counts 0..31; at count 31 the FSM SHALL go to FIN.
REQ-017 FIN SHALL last one cycle with done=1, and SHALL write LO=quotient and HI=remainder at its closing edge, then return to IDLE.
REQ-018 Sign rules for DIV: the quotient SHALL be negated when operand signs differ, and the remainder SHALL take the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-019 A zero divisor SHALL cause IDLE to go directly to FIN.
- done SHALL pulse, and HI/LO SHALL remain unchanged.
REQ-020 In IDLE without op_start, hi_we SHALL load HI and lo_we SHALL load LO from wdata at the next edge; both may assert together.
REQ-021 When op_start and hi_we/lo_we occur in the same cycle, op_start SHALL take priority and the writes SHALL be dropped.
REQ-022 While busy (DIV/FIN), op_start, hi_we and lo_we SHALL be ignored.
REQ-023 flush in DIV or FIN SHALL return the FSM to IDLE at the next edge.
- HI/LO SHALL remain unchanged and done SHALL not assert.
- flush in IDLE SHALL suppress that cycle's op_start.
REQ-024 done SHALL be 0 in every state other than FIN.

Reset
REQ-025 rst SHALL asynchronously force state=IDLE, HI=LO=0, counter=0 and the operand/partial-remainder registers to 0.
- busy and done SHALL then be 0 while rst is held.
REQ-026 rst asserted mid-division SHALL abandon the division with no HI/LO update.
- The first op_start after release SHALL be accepted normally.

Structure
REQ-027 The op_sel encodings and the FSM state encodings (IDLE, DIV, FIN) SHALL live in the shared defines header used by the controller.
REQ-028 The iterative divider datapath SHALL be a sub-module div_core.
- hilo_muldiv SHALL own HI/LO, the multiplier and the FSM.

Verification
REQ-029 hi_we with wdata=0x12345678, then lo_we with wdata=0xDEADBEEF -> hi_o=0x12345678 and lo_o=0xDEADBEEF, each one edge after its write.
REQ-030 MULT with src_a=0xFFFFFFFD, src_b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU with the same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- busy stays 0 for both.
REQ-031 DIV with src_a=0xFFFFFFF9, src_b=2 -> busy high for 34 cycles and done high in cycle 34 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/2 -> LO=3, HI=1.
REQ-032 DIV with src_b=0 and HI/LO preloaded to 0xAAAA0000/0x0000BBBB -> busy for 2 cycles, one done pulse, HI/LO unchanged.
REQ-033 flush asserted in DIV cycle 10 -> IDLE next cycle, no done, HI/LO unchanged.
- A MULT issued in the following cycle completes normally.
REQ-034 rst asserted at DIV cycle 20 -> busy, done, hi_o and lo_o all 0 immediately, without waiting for a clock edge.
- A DIVU 100/7 issued after release yields LO=14, HI=2.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation selects,
// controller state encodings and small arithmetic helpers.
package hilo_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DIV  = 2'b01,
        S_FIN  = 2'b10
    } state_e;

    localparam logic [4:0] LAST_ITER = 5'd31;

    // Magnitude of a word; 0x80000000 maps onto itself, which the divider
    // treats correctly as an unsigned 2^31.
    function automatic logic [31:0] absVal(input logic [31:0] value, input logic signedOp);
        return (signedOp && value[31]) ? (~value + 32'd1) : value;
    endfunction

    function automatic logic [31:0] negateIf(input logic [31:0] value, input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Pipeline-side bundle of the HI/LO unit: MTHI/MTLO writes, operation
// requests, flush, and the stall/completion/HI/LO results.
interface hilo_muldiv_if;

    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        op_start;
    logic [1:0]  op_sel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output hi_we, lo_we, wdata, op_start, op_sel, src_a, src_b, flush,
        input  busy, done, hi_o, lo_o
    );

    modport slave (
        input  hi_we, lo_we, wdata, op_start, op_sel, src_a, src_b, flush,
        output busy, done, hi_o, lo_o
    );

endinterface

// File: rtl/hilo_muldiv_div_core.sv
// Iterative restoring divider: operands are latched as magnitudes, one
// quotient bit is produced per step, and signs are restored on the outputs.
module div_core
    import hilo_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dsr_q, dsr_d;
    logic        negQuo_q, negQuo_d;
    logic        negRem_q, negRem_d;
    logic [33:0] shifted;
    logic [33:0] trial;

    // The quotient register starts out holding the dividend magnitude and
    // shifts its top bit into the partial remainder each step.
    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        negQuo_d = negQuo_q;
        negRem_d = negRem_q;
        shifted  = {rem_q, quo_q[31]};
        trial    = shifted - {2'b00, dsr_q};

        if (load_i) begin
            rem_d    = '0;
            quo_d    = absVal(dividend_i, signed_i);
            dsr_d    = absVal(divisor_i, signed_i);
            negQuo_d = signed_i && (dividend_i[31] ^ divisor_i[31]);
            negRem_d = signed_i && dividend_i[31];
        end else if (step_i) begin
            if (!trial[33]) begin
                rem_d = trial[32:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[32:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            negQuo_q <= 1'b0;
            negRem_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            negQuo_q <= negQuo_d;
            negRem_q <= negRem_d;
        end
    end

    assign quotient_o  = negateIf(quo_q, negQuo_q);
    assign remainder_o = negateIf(rem_q[31:0], negRem_q);

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register file with single-cycle multiply and a 32-cycle divide,
// sequenced by an IDLE/DIV/FIN controller that stalls the pipeline via busy.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hilo_muldiv_if.slave bus
);

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        divZero_q, divZero_d;

    logic        startOk;
    logic        isDiv;
    logic        signedOp;
    logic [63:0] aExt, bExt, product;
    logic        divLoad, divStep;
    logic [31:0] quotient, remainder;
    logic        busy, done;

    assign startOk  = bus.op_start && !bus.flush;
    assign isDiv    = (bus.op_sel == OP_DIV) || (bus.op_sel == OP_DIVU);
    assign signedOp = (bus.op_sel == OP_MULT) || (bus.op_sel == OP_DIV);

    // Extending both operands to 64 bits lets one unsigned multiply serve
    // MULT and MULTU; the low 64 bits are the correct product either way.
    assign aExt    = signedOp ? {{32{bus.src_a[31]}}, bus.src_a} : {32'b0, bus.src_a};
    assign bExt    = signedOp ? {{32{bus.src_b[31]}}, bus.src_b} : {32'b0, bus.src_b};
    assign product = aExt * bExt;

    div_core u_div (
        .clk         (clk),
        .rst         (rst),
        .load_i      (divLoad),
        .step_i      (divStep),
        .signed_i    (signedOp),
        .dividend_i  (bus.src_a),
        .divisor_i   (bus.src_b),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divZero_d = divZero_q;
        divLoad   = 1'b0;
        divStep   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                count_d   = '0;
                divZero_d = 1'b0;
                if (startOk) begin
                    if (isDiv) begin
                        busy = 1'b1;
                        if (bus.src_b == 32'd0) begin
                            divZero_d = 1'b1;
                            state_d   = S_FIN;
                        end else begin
                            divLoad = 1'b1;
                            state_d = S_DIV;
                        end
                    end else begin
                        hi_d = product[63:32];
                        lo_d = product[31:0];
                    end
                end else if (!bus.op_start) begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end

            S_DIV: begin
                busy = 1'b1;
                if (bus.flush) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else begin
                    divStep = 1'b1;
                    count_d = count_q + 5'd1;
                    if (count_q == LAST_ITER) state_d = S_FIN;
                end
            end

            S_FIN: begin
                busy    = 1'b1;
                state_d = S_IDLE;
                if (!bus.flush) begin
                    done = 1'b1;
                    if (!divZero_q) begin
                        hi_d = remainder;
                        lo_d = quotient;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // While reset is held the accept path must not raise a stall.
        if (rst) begin
            busy = 1'b0;
            done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divZero_q <= divZero_d;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi_o = hi_q;
    assign bus.lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: inputs change on the falling edge and
// outputs are sampled 1ns later, against hand-computed expected values.
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    hilo_muldiv_if bif ();

    hilo_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic hiWe, input logic loWe, input logic [31:0] wd,
                                 input logic start, input logic [1:0] sel,
                                 input logic [31:0] a, input logic [31:0] b, input logic fl);
        @(negedge clk);
        bif.hi_we    = hiWe;
        bif.lo_we    = loWe;
        bif.wdata    = wd;
        bif.op_start = start;
        bif.op_sel   = sel;
        bif.src_a    = a;
        bif.src_b    = b;
        bif.flush    = fl;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        #1;
    endtask

    // Issues one divide and follows it until busy drops or the budget runs out.
    task automatic runDivide(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                             output int busyCycles, output int doneCycle, output int donePulses);
        busyCycles = 0;
        doneCycle  = 0;
        donePulses = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, (cyc == 1), sel, a, b, 1'b0);
            #1;
            if (bif.busy) busyCycles++;
            if (bif.done) begin
                donePulses++;
                doneCycle = cyc;
            end
            if (!bif.busy) break;
        end
    endtask

    int busyCycles, doneCycle, donePulses;
    int doneSeen;

    initial begin
        bif.hi_we    = 1'b0;
        bif.lo_we    = 1'b0;
        bif.wdata    = 32'd0;
        bif.op_start = 1'b1;
        bif.op_sel   = OP_DIV;
        bif.src_a    = 32'd9;
        bif.src_b    = 32'd1;
        bif.flush    = 1'b0;
        rst          = 1'b1;

        #1;
        checkOutput("reset_hi", bif.hi_o, 32'd0);
        checkOutput("reset_lo", bif.lo_o, 32'd0);
        checkOutput("reset_busy", {31'd0, bif.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bif.done}, 32'd0);
        repeat (2) @(posedge clk);
        idleCycle();
        rst = 1'b0;
        idleCycle();

        // MTHI then MTLO, each visible one edge after its write
        applyStimulus(1'b1, 1'b0, 32'h12345678, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("mthi_hi", bif.hi_o, 32'h12345678);
        checkOutput("mthi_lo_still", bif.lo_o, 32'd0);
        idleCycle();
        checkOutput("mtlo_lo", bif.lo_o, 32'hDEADBEEF);

        // MULT and MULTU of 0xFFFFFFFD by 5
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
        #1;
        checkOutput("mult_busy", {31'd0, bif.busy}, 32'd0);
        idleCycle();
        checkOutput("mult_hi", bif.hi_o, 32'hFFFFFFFF);
        checkOutput("mult_lo", bif.lo_o, 32'hFFFFFFF1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, OP_MULTU, 32'hFFFFFFFD, 32'd5, 1'b0);
        #1;
        checkOutput("multu_busy", {31'd0, bif.busy}, 32'd0);
        idleCycle();
        checkOutput("multu_hi", bif.hi_o, 32'h00000004);
        checkOutput("multu_lo", bif.lo_o, 32'hFFFFFFF1);

        // op_start wins over simultaneous HI/LO writes
        applyStimulus(1'b1, 1'b1, 32'h55555555, 1'b1, OP_MULTU, 32'd3, 32'd4, 1'b0);
        idleCycle();
        checkOutput("prio_hi", bif.hi_o, 32'd0);
        checkOutput("prio_lo", bif.lo_o, 32'd12);

        // Signed divide -7 / 2
        runDivide(OP_DIV, 32'hFFFFFFF9, 32'd2, busyCycles, doneCycle, donePulses);
        checkOutput("div_busy_cycles", busyCycles, 32'd34);
        checkOutput("div_done_cycle", doneCycle, 32'd34);
        checkOutput("div_done_pulses", donePulses, 32'd1);
        checkOutput("div_lo", bif.lo_o, 32'hFFFFFFFD);
        checkOutput("div_hi", bif.hi_o, 32'hFFFFFFFF);

        runDivide(OP_DIVU, 32'd7, 32'd2, busyCycles, doneCycle, donePulses);
        checkOutput("divu_lo", bif.lo_o, 32'd3);
        checkOutput("divu_hi", bif.hi_o, 32'd1);

        // Most-negative by minus one
        runDivide(OP_DIV, 32'h80000000, 32'hFFFFFFFF, busyCycles, doneCycle, donePulses);
        checkOutput("divovf_lo", bif.lo_o, 32'h80000000);
        checkOutput("divovf_hi", bif.hi_o, 32'd0);

        // Divide by zero: short stall, one done pulse, HI/LO untouched
        applyStimulus(1'b1, 1'b0, 32'hAAAA0000, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000BBBB, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        runDivide(OP_DIV, 32'd12345, 32'd0, busyCycles, doneCycle, donePulses);
        checkOutput("div0_busy_cycles", busyCycles, 32'd2);
        checkOutput("div0_done_pulses", donePulses, 32'd1);
        checkOutput("div0_hi", bif.hi_o, 32'hAAAA0000);
        checkOutput("div0_lo", bif.lo_o, 32'h0000BBBB);

        // Flush in DIV cycle 10, with writes/starts attempted while busy
        applyStimulus(1'b1, 1'b1, 32'h0000CAFE, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        doneSeen = 0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, OP_DIVU, 32'd1000, 32'd3, 1'b0);
        for (int cyc = 2; cyc <= 10; cyc++) begin
            applyStimulus(1'b1, 1'b1, 32'hBAD0BAD0, 1'b1, OP_MULT, 32'd5, 32'd5, 1'b0);
            #1;
            if (bif.done) doneSeen++;
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b1);
        #1;
        checkOutput("flush_busy_in_div", {31'd0, bif.busy}, 32'd1);
        if (bif.done) doneSeen++;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
        #1;
        checkOutput("flush_idle_busy", {31'd0, bif.busy}, 32'd0);
        checkOutput("flush_hi_kept", bif.hi_o, 32'h0000CAFE);
        checkOutput("flush_lo_kept", bif.lo_o, 32'h0000CAFE);
        if (bif.done) doneSeen++;
        idleCycle();
        checkOutput("flush_no_done", doneSeen, 32'd0);
        checkOutput("post_flush_mult_hi", bif.hi_o, 32'hFFFFFFFF);
        checkOutput("post_flush_mult_lo", bif.lo_o, 32'hFFFFFFEB);

        // Flush in IDLE suppresses that cycle's op_start
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, OP_MULTU, 32'd2, 32'd3, 1'b1);
        idleCycle();
        checkOutput("idle_flush_hi", bif.hi_o, 32'hFFFFFFFF);
        checkOutput("idle_flush_lo", bif.lo_o, 32'hFFFFFFEB);

        // Reset at DIV cycle 20 clears everything without a clock edge
        applyStimulus(1'b1, 1'b1, 32'h11112222, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, OP_DIVU, 32'd1000, 32'd3, 1'b0);
        for (int cyc = 2; cyc <= 21; cyc++) idleCycle();
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_busy", {31'd0, bif.busy}, 32'd0);
        checkOutput("rst_mid_done", {31'd0, bif.done}, 32'd0);
        checkOutput("rst_mid_hi", bif.hi_o, 32'd0);
        checkOutput("rst_mid_lo", bif.lo_o, 32'd0);
        idleCycle();
        rst = 1'b0;
        runDivide(OP_DIVU, 32'd100, 32'd7, busyCycles, doneCycle, donePulses);
        checkOutput("post_rst_busy_cycles", busyCycles, 32'd34);
        checkOutput("post_rst_lo", bif.lo_o, 32'd14);
        checkOutput("post_rst_hi", bif.hi_o, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
